// File: rtl/mem_access_unit.sv
// Byte/half/word load-store adapter onto a word-wide memory; sub-word stores use read-modify-write.
// Latency: error 1 cycle, load/word store 2+waits, sub-word store 3+waits; req_ready only while idle.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word_q;
  logic              accept, req_bad;
  logic [31:0]       merged, load_data;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_bad   = (req_size == 2'd2) ||
                     (req_size == 2'd1 && req_addr[0]) ||
                     (req_size == 2'd3 && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_bad)                           state_nxt = DONE;
        else if (req_we && req_size == 2'd3)   state_nxt = WR;
        else                                   state_nxt = RD;
      end
      RD:   if (mem_ack) state_nxt = we_q ? WR : DONE;
      WR:   if (mem_ack) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_bad;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      // Read word serves both as load source and as the merge base for sub-word stores.
      if (state == RD && mem_ack) word_q <= mem_rdata;
    end
  end

  always_comb begin
    merged = word_q;
    case (size_q)
      2'd0:    merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'd1:    merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign lane_h = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    load_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'd1:    load_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_data = word_q;
    endcase
  end

  assign mem_req    = (state == RD) || (state == WR);
  assign mem_we     = (state == WR);
  assign mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = (state == WR) ? merged : 32'd0;
  assign resp_valid = (state == DONE);
  assign resp_err   = (state == DONE) && err_q;
  assign resp_rdata = (state == DONE && !we_q && !err_q) ? load_data : 32'd0;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of the byte address on both the CPU side and the memory side.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  unit idle and able to accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 byte, 1 half, 3 word, 2 reserved.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 resp_err  output  1  misaligned or reserved-size request, valid with resp_valid.
REQ-014 mem_req  output  1  word-memory access request.
REQ-015 mem_we  output  1  1 = write word, 0 = read word.
REQ-016 mem_addr  output  ADDR_W  word address, with bits [1:0] always 0.
REQ-017 mem_wdata  output  32  full write word.
REQ-018 mem_ack  input  1  memory completed the current access; mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  input  32  read word, little-endian (byte 0 in bits [7:0]).

Function
REQ-020 FSM states: IDLE, RD, WR, DONE; req_ready = (state==IDLE) and not reset.
REQ-021 Accept a request on an edge where req_valid and req_ready are both 1; latch we, size, unsigned, addr and wdata at that edge.
REQ-022 Error check at acceptance: size 2, half with addr[0]=1, or word with addr[1:0]!=0 -> go to DONE with resp_err=1 and make no memory access.
REQ-023 Transitions for a legal request: a load goes IDLE->RD; a word store goes IDLE->WR; a byte or half store goes IDLE->RD (read-modify-write).
REQ-024 From RD, on mem_ack: a load goes to DONE; a sub-word store goes to WR, capturing mem_rdata as the merge word.
REQ-025 From WR, on mem_ack, go to DONE.
REQ-026 From DONE, go to IDLE unconditionally; a new request can therefore be accepted on the edge after resp_valid.
REQ-027 mem_req = 1 exactly in RD and WR.
REQ-028 mem_we = 1 only in WR.
REQ-029 mem_addr = {latched addr[ADDR_W-1:2], 2'b00}, held stable while mem_req = 1.
REQ-030 mem_req stays high across wait cycles until mem_ack; there is no timeout.
REQ-031 mem_ack is ignored outside RD and WR.
REQ-032 Store merge: byte replaces lane addr[1:0] with wdata[7:0]; half replaces lanes {addr[1],1}/{addr[1],0} with wdata[15:0]; all other lanes keep the read word; a word store passes wdata unchanged.
REQ-033 Load extraction: byte = lane addr[1:0]; half = lanes selected by addr[1]; extend per req_unsigned; a word load is passed through.
REQ-034 resp_valid = 1 only in DONE.
REQ-035 resp_rdata is 0 for stores and for errors.
REQ-036 resp_err = 0 in DONE for legal requests.
REQ-037 Minimum latency with zero-wait memory (mem_ack in the first mem_req cycle): load or word store = resp_valid 2 cycles after acceptance; sub-word store = 3 cycles; error = 1 cycle.
REQ-038 The unit never issues a write to a word whose read in the same transaction has not been acknowledged.

Reset
REQ-039 While reset = 1: state = IDLE; mem_req, mem_we, resp_valid and resp_err = 0; mem_addr, mem_wdata, resp_rdata and all latched fields = 0.
REQ-040 Reset mid-transaction abandons the access immediately: mem_req drops asynchronously, no response is produced, and no write is issued afterwards.
REQ-041 After reset release, the first rising edge can accept a request.

Verification
REQ-042 Load byte signed, addr 0x1003, mem_rdata 0x80FF1234, zero-wait -> mem_addr 0x1000, mem_we 0, resp_rdata 0xFFFFFF80, resp_err 0, 2 cycles.
REQ-043 Store half, addr 0x2002, wdata 0x0000BEEF, read returns 0x11223344 -> RD then WR, mem_wdata 0xBEEF3344, resp_valid 3 cycles after accept.
REQ-044 Load word, addr 0x0006 -> resp_err 1, resp_rdata 0, mem_req never asserted, resp 1 cycle after accept.
REQ-045 Load half unsigned, addr 0x0002, mem_ack delayed 4 cycles, mem_rdata 0x9ABC0000 -> mem_req high 5 cycles with constant addr 0x0000, resp_rdata 0x00009ABC.
REQ-046 Store byte, reset asserted during RD wait -> mem_req 0 in same cycle, no WR cycle, no resp_valid, req_ready 1 after release.
REQ-047 Back-to-back: req_valid held high with two word stores -> second accepted on the edge after first resp_valid, mem_ack pulses outside RD/WR have no effect.
